sdram_wfifo_ctrl: RTL and testbench

SDRAM_WFIFO_CTRL -- requirements
Module: sdram_wfifo_ctrl

---
 rtl/sdram_wfifo_ctrl_if.sv | 36 +++
 rtl/sdram_wfifo_ctrl.sv | 158 +++++++++++++++
 tb/tb_sdram_wfifo_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_wfifo_ctrl_if.sv
// Byte-stream bundle between the upstream producer, the write FIFO and the SDRAM write stage.
// slave is the FIFO side; master is the side that drives in_* and wfifo_rd_en.
interface sdram_wfifo_ctrl_if #(
    parameter int AW = 4
);
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic        wfifo_rd_en;
    logic [7:0]  wfifo_rd_data;
    logic        wr_trig;
    logic [AW:0] fifo_cnt;
    logic        udf_err;

    modport slave (
        input  in_data,
        input  in_vld,
        input  wfifo_rd_en,
        output in_rdy,
        output wfifo_rd_data,
        output wr_trig,
        output fifo_cnt,
        output udf_err
    );

    modport master (
        output in_data,
        output in_vld,
        output wfifo_rd_en,
        input  in_rdy,
        input  wfifo_rd_data,
        input  wr_trig,
        input  fifo_cnt,
        input  udf_err
    );
endinterface

// File: rtl/sdram_wfifo_ctrl.sv
// Byte write FIFO feeding an SDRAM write stage, with a trigger FSM that requests
// one write burst of TRIG_LVL bytes whenever the fill level reaches TRIG_LVL.
module sdram_wfifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TRIG_LVL = 4
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    sdram_wfifo_ctrl_if.slave    bus
);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   TRIG_C   = (AW+1)'(TRIG_LVL);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = (AW)'(0);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          udf_q, udf_d;
    logic          trig_q, trig_d;
    logic [AW:0]   bcnt_q, bcnt_d;
    state_t        state_q, state_d;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign full_s  = (cnt_q == DEPTH_C);
    assign empty_s = (cnt_q == CNT_ZERO);
    assign push_s  = bus.in_vld && !full_s;
    assign pop_s   = bus.wfifo_rd_en && !empty_s;

    assign bus.in_rdy        = !full_s;
    assign bus.fifo_cnt      = cnt_q;
    assign bus.wfifo_rd_data = rd_data_q;
    assign bus.wr_trig       = trig_q;
    assign bus.udf_err       = udf_q;

    // Pointer, occupancy, read-data and underflow next-state logic.
    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        udf_d     = udf_q;

        if (push_s) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d      = rp_q + PTR_ONE;
            rd_data_d = mem_q[rp_q];
        end else begin
            rp_d      = rp_q;
            rd_data_d = rd_data_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // A pop against an empty FIFO is dropped but latched as an error until reset.
        if (bus.wfifo_rd_en && empty_s) begin
            udf_d = 1'b1;
        end else begin
            udf_d = udf_q;
        end
    end

    // Trigger FSM next-state: one request, then count TRIG_LVL accepted pops.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            S_IDLE: begin
                if (cnt_q >= TRIG_C) begin
                    state_d = S_TRIG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRIG: begin
                state_d = S_WAIT;
                bcnt_d  = CNT_ZERO;
            end
            S_WAIT: begin
                if (pop_s) begin
                    bcnt_d = bcnt_q + CNT_ONE;
                    if (bcnt_d == TRIG_C) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    bcnt_d  = bcnt_q;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                bcnt_d  = CNT_ZERO;
            end
        endcase

        trig_d = (state_d == S_TRIG);
    end

    // Control and status registers.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wp_q      <= PTR_ZERO;
            rp_q      <= PTR_ZERO;
            cnt_q     <= CNT_ZERO;
            rd_data_q <= 8'h00;
            udf_q     <= 1'b0;
            trig_q    <= 1'b0;
            bcnt_q    <= CNT_ZERO;
            state_q   <= S_IDLE;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            udf_q     <= udf_d;
            trig_q    <= trig_d;
            bcnt_q    <= bcnt_d;
            state_q   <= state_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_q[wp_q] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_sdram_wfifo_ctrl.sv
// Randomized and directed bench for sdram_wfifo_ctrl against a queue-based reference model.
module tb_sdram_wfifo_ctrl;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int TRIG_LVL = 4;

    logic sclk  = 1'b0;
    logic s_rst = 1'b1;

    sdram_wfifo_ctrl_if #(.AW(AW)) bus();

    sdram_wfifo_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .TRIG_LVL (TRIG_LVL)
    ) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue holds the FIFO contents, mode 0/1/2 = idle/requesting/bursting.
    logic [7:0] mq[$];
    logic [7:0] m_data;
    bit         m_udf;
    int         m_mode;
    int         m_pops;
    int         trig_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/cnt"},  32'(bus.fifo_cnt),      32'(mq.size()));
        chk({tag, "/rdy"},  32'(bus.in_rdy),        32'(mq.size() != DEPTH));
        chk({tag, "/data"}, 32'(bus.wfifo_rd_data), 32'(m_data));
        chk({tag, "/trig"}, 32'(bus.wr_trig),       32'(m_mode == 1));
        chk({tag, "/udf"},  32'(bus.udf_err),       32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = 8'h00;
        m_udf  = 1'b0;
        m_mode = 0;
        m_pops = 0;
    endtask

    task automatic model_step(input bit vld, input logic [7:0] d, input bit rd);
        int  n;
        bit  push;
        bit  pop;
        n    = mq.size();
        push = vld && (n != DEPTH);
        pop  = rd && (n != 0);
        if (rd && n == 0) m_udf = 1'b1;
        if (m_mode == 0) begin
            if (n >= TRIG_LVL) m_mode = 1;
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_pops = 0;
        end else begin
            if (pop) begin
                m_pops++;
                if (m_pops == TRIG_LVL) m_mode = 0;
            end
        end
        if (pop)  m_data = mq.pop_front();
        if (push) mq.push_back(d);
    endtask

    // One clock: inputs applied after the previous edge, outputs checked 1 ns after this edge.
    task automatic cycle(input bit vld, input logic [7:0] d, input bit rd);
        bus.in_vld      = vld;
        bus.in_data     = d;
        bus.wfifo_rd_en = rd;
        @(posedge sclk);
        #1;
        model_step(vld, d, rd);
        if (bus.wr_trig) trig_seen++;
        check_outputs("cyc");
    endtask

    // Reset lands between edges, so the outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        bus.in_vld      = 1'b0;
        bus.wfifo_rd_en = 1'b0;
        bus.in_data     = 8'h00;
        s_rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        check_outputs({tag, "_rel"});
    endtask

    initial begin
        bus.in_vld      = 1'b0;
        bus.in_data     = 8'h00;
        bus.wfifo_rd_en = 1'b0;
        model_reset();
        trig_seen = 0;
        repeat (2) @(posedge sclk);
        #1;
        check_outputs("por");
        s_rst = 1'b0;

        // Four pushes, one request, four pops returning the bytes in order.
        trig_seen = 0;
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("basic_trig_pulse", 32'(bus.wr_trig), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("basic_last_byte", 32'(bus.wfifo_rd_data), 32'h44);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        chk("basic_trig_count", 32'(trig_seen), 32'd1);

        // Pop on empty: dropped, flagged, and the flag sticks.
        cycle(1'b0, 8'h00, 1'b1);
        chk("udf_set", 32'(bus.udf_err), 32'd1);
        repeat (3) cycle(1'b1, 8'h5A, 1'b0);
        chk("udf_sticky", 32'(bus.udf_err), 32'd1);
        do_reset("rst_udf");

        // Fill to full with in_vld held, then pop+push while full.
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
        chk("full_rdy", 32'(bus.in_rdy), 32'd0);
        chk("full_cnt", 32'(bus.fifo_cnt), 32'd16);
        cycle(1'b1, 8'hEE, 1'b1);
        chk("full_poppush_cnt", 32'(bus.fifo_cnt), 32'd15);
        for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 1'b1);
        do_reset("rst_full");

        // Ten bytes, pop only while a burst is open: two requests, two bytes left.
        trig_seen = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, (m_mode == 2));
        chk("burst2_trigs", 32'(trig_seen), 32'd2);
        chk("burst2_left", 32'(bus.fifo_cnt), 32'd2);
        do_reset("rst_b2");

        // Twenty bytes across four pops so both pointers wrap.
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 12; i < 16; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
        for (int i = 16; i < 20; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        chk("wrap_cnt", 32'(bus.fifo_cnt), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_last", 32'(bus.wfifo_rd_data), 32'h73);
        do_reset("rst_wrap");

        // Reset mid-burst after two pops; re-arm needs TRIG_LVL fresh bytes.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        do_reset("rst_mid");
        trig_seen = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        chk("rearm_3_none", 32'(trig_seen), 32'd0);
        cycle(1'b1, 8'hD3, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("rearm_4_one", 32'(trig_seen), 32'd1);
        do_reset("rst_rand");

        // Random traffic with shifting push/pop bias and one asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            int pv;
            int pr;
            pv = ((i / 300) % 2 == 0) ? 65 : 35;
            pr = ((i / 300) % 2 == 0) ? 35 : 65;
            if (i == 1500) do_reset("rst_rnd_mid");
            cycle(($urandom_range(0, 99) < pv), 8'($urandom), ($urandom_range(0, 99) < pr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
